// File: rtl/rv32i_types.sv
// Shared branch-prediction types: 2-bit counter encoding, queue entry layout
// and the saturating counter update used by both the LHT and the update queue.
package rv32i_types;

  localparam int unsigned LHT_DEPTH = 64;
  localparam int unsigned BQ_DEPTH  = 8;
  localparam int unsigned LHT_IDX_W = $clog2(LHT_DEPTH);

  // Predicted direction is state[1].
  typedef enum logic [1:0] {
    snt = 2'b00,
    wnt = 2'b01,
    wt  = 2'b10,
    st  = 2'b11
  } bp_state_t;

  typedef struct packed {
    logic                 valid;
    logic                 resolved;
    logic                 taken;
    logic [LHT_IDX_W-1:0] idx;
    bp_state_t            state;
  } bq_entry_t;

  function automatic bp_state_t bp_next_state(input bp_state_t state, input logic taken);
    bp_state_t nxt;
    nxt = state;
    case (state)
      snt:     nxt = taken ? wnt : snt;
      wnt:     nxt = taken ? wt  : snt;
      wt:      nxt = taken ? st  : wnt;
      st:      nxt = taken ? st  : wt;
      default: nxt = state;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/branch_update_queue.sv
// In-order branch update queue: allocates at decode, resolves out of order by
// tag, retires from the head into a registered LHT write. BUQ_STATE_FWD_EN
// forwards a retiring counter update to younger entries on the same index.
module branch_update_queue
  import rv32i_types::*;
#(
  parameter  int unsigned BQ_DEPTH = rv32i_types::BQ_DEPTH,
  localparam int unsigned TAG_W    = $clog2(BQ_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enq_valid,
  input  logic [LHT_IDX_W-1:0] enq_idx,
  input  bp_state_t            enq_state,
  output logic                 enq_ready,
  output logic [TAG_W-1:0]     enq_tag,
  input  logic                 res_valid,
  input  logic [TAG_W-1:0]     res_tag,
  input  logic                 res_taken,
  output logic                 res_mispredict,
  input  logic                 flush,
  output logic                 branch_we,
  output logic [LHT_IDX_W-1:0] write_idx,
  output logic                 branch_taken,
  output bp_state_t            bp_prev_state
);

  localparam int unsigned CNT_W = TAG_W + 1;

  bq_entry_t            entries_q [BQ_DEPTH];
  bq_entry_t            entries_d [BQ_DEPTH];
  logic [TAG_W-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 branch_we_q, branch_we_d;
  logic [LHT_IDX_W-1:0] write_idx_q, write_idx_d;
  logic                 branch_taken_q, branch_taken_d;
  bp_state_t            bp_prev_state_q, bp_prev_state_d;

  logic enq_fire, res_hit, retire;

  assign enq_ready = (count_q < CNT_W'(BQ_DEPTH));
  assign enq_tag   = tail_q;
  assign enq_fire  = enq_valid && enq_ready && !flush;
  assign res_hit   = res_valid && !flush && entries_q[res_tag].valid && !entries_q[res_tag].resolved;
  assign retire    = entries_q[head_q].valid && entries_q[head_q].resolved && !flush;

  assign res_mispredict = res_hit && (res_taken != entries_q[res_tag].state[1]);

  assign branch_we     = branch_we_q;
  assign write_idx     = write_idx_q;
  assign branch_taken  = branch_taken_q;
  assign bp_prev_state = bp_prev_state_q;

`ifdef BUQ_STATE_FWD_EN
  bp_state_t fwd_state;
  assign fwd_state = bp_next_state(entries_q[head_q].state, entries_q[head_q].taken);
`endif

  // Next-state for entry array, pointers and the LHT update stage.
  always_comb begin
    entries_d       = entries_q;
    head_d          = head_q;
    tail_d          = tail_q;
    count_d         = count_q;
    branch_we_d     = 1'b0;
    write_idx_d     = write_idx_q;
    branch_taken_d  = branch_taken_q;
    bp_prev_state_d = bp_prev_state_q;

    if (flush) begin
      for (int unsigned i = 0; i < BQ_DEPTH; i++) begin
        entries_d[TAG_W'(i)].valid    = 1'b0;
        entries_d[TAG_W'(i)].resolved = 1'b0;
      end
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (res_hit) begin
        entries_d[res_tag].resolved = 1'b1;
        entries_d[res_tag].taken    = res_taken;
      end

      if (retire) begin
        branch_we_d     = 1'b1;
        write_idx_d     = entries_q[head_q].idx;
        branch_taken_d  = entries_q[head_q].taken;
        bp_prev_state_d = entries_q[head_q].state;
`ifdef BUQ_STATE_FWD_EN
        for (int unsigned i = 0; i < BQ_DEPTH; i++) begin
          if (TAG_W'(i) != head_q && entries_q[TAG_W'(i)].valid &&
              entries_q[TAG_W'(i)].idx == entries_q[head_q].idx) begin
            entries_d[TAG_W'(i)].state = fwd_state;
          end
        end
`endif
        entries_d[head_q] = '0;
        head_d            = head_q + TAG_W'(1);
      end

      if (enq_fire) begin
        entries_d[tail_q].valid    = 1'b1;
        entries_d[tail_q].resolved = 1'b0;
        entries_d[tail_q].taken    = 1'b0;
        entries_d[tail_q].idx      = enq_idx;
        entries_d[tail_q].state    = enq_state;
`ifdef BUQ_STATE_FWD_EN
        // A same-cycle retire on this index supersedes the stale LHT read.
        if (retire && enq_idx == entries_q[head_q].idx) begin
          entries_d[tail_q].state = fwd_state;
        end
`endif
        tail_d = tail_q + TAG_W'(1);
      end

      if (enq_fire && !retire) begin
        count_d = count_q + CNT_W'(1);
      end else if (!enq_fire && retire) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < BQ_DEPTH; i++) begin
        entries_q[TAG_W'(i)] <= '0;
      end
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      branch_we_q     <= 1'b0;
      write_idx_q     <= '0;
      branch_taken_q  <= 1'b0;
      bp_prev_state_q <= wnt;
    end else begin
      entries_q       <= entries_d;
      head_q          <= head_d;
      tail_q          <= tail_d;
      count_q         <= count_d;
      branch_we_q     <= branch_we_d;
      write_idx_q     <= write_idx_d;
      branch_taken_q  <= branch_taken_d;
      bp_prev_state_q <= bp_prev_state_d;
    end
  end

endmodule

// File: tb/tb_branch_update_queue.sv
// Bench for branch_update_queue: directed vector table, corner sequences and
// random traffic against an in-order list model of in-flight branches.
module tb_branch_update_queue;
  import rv32i_types::*;

  localparam int DEPTH = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 enq_valid;
  logic [LHT_IDX_W-1:0] enq_idx;
  bp_state_t            enq_state;
  logic                 enq_ready;
  logic [2:0]           enq_tag;
  logic                 res_valid;
  logic [2:0]           res_tag;
  logic                 res_taken;
  logic                 res_mispredict;
  logic                 flush;
  logic                 branch_we;
  logic [LHT_IDX_W-1:0] write_idx;
  logic                 branch_taken;
  bp_state_t            bp_prev_state;

  always #5 clk = ~clk;

  branch_update_queue #(.BQ_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .enq_valid(enq_valid), .enq_idx(enq_idx), .enq_state(enq_state),
    .enq_ready(enq_ready), .enq_tag(enq_tag),
    .res_valid(res_valid), .res_tag(res_tag), .res_taken(res_taken),
    .res_mispredict(res_mispredict), .flush(flush),
    .branch_we(branch_we), .write_idx(write_idx),
    .branch_taken(branch_taken), .bp_prev_state(bp_prev_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: program-ordered list of in-flight branches plus the update stage.
  typedef struct {
    int tag;
    int idx;
    int cs;
    bit res;
    bit tk;
  } m_ent_t;

  m_ent_t mq[$];
  int m_tail, m_we, m_widx, m_tk, m_prev;

  task automatic model_reset();
    mq.delete();
    m_tail = 0; m_we = 0; m_widx = 0; m_tk = 0; m_prev = 1;
  endtask

  function automatic int m_find(input int tag);
    foreach (mq[k]) if (mq[k].tag == tag && !mq[k].res) return k;
    return -1;
  endfunction

  task automatic model_edge(input bit ev, input int ei, input int es, input bit rv,
                            input int rt, input bit rtk, input bit fl);
    bit ready, retire;
    int r, es_eff;
    m_ent_t h, n;
    ready  = mq.size() < DEPTH;
    es_eff = es;
    if (fl) begin
      mq.delete();
      m_tail = 0;
      m_we   = 0;
      return;
    end
    r      = m_find(rt);
    retire = mq.size() > 0 && mq[0].res;
    if (rv && r >= 0) begin
      mq[r].res = 1;
      mq[r].tk  = rtk;
    end
    if (retire) begin
      h = mq.pop_front();
      m_we = 1; m_widx = h.idx; m_tk = int'(h.tk); m_prev = h.cs;
`ifdef BUQ_STATE_FWD_EN
      begin
        int nx;
        nx = h.tk ? ((h.cs == 3) ? 3 : h.cs + 1) : ((h.cs == 0) ? 0 : h.cs - 1);
        foreach (mq[k]) if (mq[k].idx == h.idx) mq[k].cs = nx;
        if (ei == h.idx) es_eff = nx;
      end
`endif
    end else begin
      m_we = 0;
    end
    if (ev && ready) begin
      n.tag = m_tail; n.idx = ei; n.cs = es_eff; n.res = 0; n.tk = 0;
      mq.push_back(n);
      m_tail = (m_tail + 1) % DEPTH;
    end
  endtask

  task automatic drive(input bit ev, input int ei, input int es, input bit rv,
                       input int rt, input bit rtk, input bit fl);
    logic [31:0] t_es, t_ei, t_rt;
    t_es = es; t_ei = ei; t_rt = rt;
    enq_valid = ev;
    enq_idx   = t_ei[LHT_IDX_W-1:0];
    enq_state = bp_state_t'(t_es[1:0]);
    res_valid = rv;
    res_tag   = t_rt[2:0];
    res_taken = rtk;
    flush     = fl;
  endtask

  // One clock: drive, compare combinational outputs, clock, compare update stage.
  task automatic step(input bit ev, input int ei, input int es, input bit rv,
                      input int rt, input bit rtk, input bit fl);
    int r, x_misp;
    drive(ev, ei, es, rv, rt, rtk, fl);
    #1;
    r      = m_find(rt);
    x_misp = (rv && !fl && r >= 0) ? int'(rtk != (mq[r].cs >= 2)) : 0;
    check("enq_ready", int'(enq_ready), int'(mq.size() < DEPTH));
    check("enq_tag", int'(enq_tag), m_tail);
    check("res_mispredict", int'(res_mispredict), x_misp);
    @(posedge clk);
    model_edge(ev, ei, es, rv, rt, rtk, fl);
    #1;
    check("branch_we", int'(branch_we), m_we);
    check("write_idx", int'(write_idx), m_widx);
    check("branch_taken", int'(branch_taken), m_tk);
    check("bp_prev_state", int'(bp_prev_state), m_prev);
  endtask

  typedef struct {
    bit ev; int ei; int es; bit rv; int rt; bit rtk; bit fl;
    int x_rdy; int x_tag; int x_misp;
    int x_we; int x_widx; int x_tk; int x_prev;
  } vec_t;

  vec_t vt[10];

  initial begin
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #12;
    check("rst_branch_we", int'(branch_we), 0);
    check("rst_write_idx", int'(write_idx), 0);
    check("rst_prev_state", int'(bp_prev_state), 1);
    check("rst_enq_ready", int'(enq_ready), 1);
    check("rst_enq_tag", int'(enq_tag), 0);
    @(posedge clk); #1;
    rst = 1'b1;

    //       ev ei es rv rt tk fl | rdy tag misp | we widx tk prev
    vt[0] = '{1, 5, 2, 0, 0, 0, 0,   1, 0, 0,   0, 0, 0, 1};
    vt[1] = '{0, 0, 0, 1, 0, 1, 0,   1, 1, 0,   0, 0, 0, 1};
    vt[2] = '{0, 0, 0, 0, 0, 0, 0,   1, 1, 0,   1, 5, 1, 2};
    vt[3] = '{1, 3, 0, 0, 0, 0, 0,   1, 1, 0,   0, 5, 1, 2};
    vt[4] = '{1, 4, 1, 1, 1, 1, 0,   1, 2, 1,   0, 5, 1, 2};
    vt[5] = '{0, 0, 0, 1, 1, 0, 0,   1, 3, 0,   1, 3, 1, 0};
    vt[6] = '{1, 7, 3, 1, 2, 0, 0,   1, 3, 0,   0, 3, 1, 0};
    vt[7] = '{0, 0, 0, 1, 5, 1, 0,   1, 4, 0,   1, 4, 0, 1};
    vt[8] = '{1, 6, 2, 1, 3, 0, 1,   1, 4, 0,   0, 4, 0, 1};
    vt[9] = '{0, 0, 0, 0, 0, 0, 0,   1, 0, 0,   0, 4, 0, 1};

    for (int v = 0; v < 10; v++) begin
      drive(vt[v].ev, vt[v].ei, vt[v].es, vt[v].rv, vt[v].rt, vt[v].rtk, vt[v].fl);
      #1;
      check($sformatf("vec%0d_ready", v), int'(enq_ready), vt[v].x_rdy);
      check($sformatf("vec%0d_tag", v), int'(enq_tag), vt[v].x_tag);
      check($sformatf("vec%0d_misp", v), int'(res_mispredict), vt[v].x_misp);
      @(posedge clk);
      model_edge(vt[v].ev, vt[v].ei, vt[v].es, vt[v].rv, vt[v].rt, vt[v].rtk, vt[v].fl);
      #1;
      check($sformatf("vec%0d_we", v), int'(branch_we), vt[v].x_we);
      check($sformatf("vec%0d_widx", v), int'(write_idx), vt[v].x_widx);
      check($sformatf("vec%0d_tk", v), int'(branch_taken), vt[v].x_tk);
      check($sformatf("vec%0d_prev", v), int'(bp_prev_state), vt[v].x_prev);
    end

    // Fill, out-of-order resolve, head-of-line blocking, full + retire.
    for (int i = 0; i < 8; i++) step(1, i, i % 4, 0, 0, 0, 0);
    check("full_ready", int'(enq_ready), 0);
    step(1, 20, 2, 0, 0, 0, 0);
    step(0, 0, 0, 1, 3, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    check("ooo_no_retire", int'(branch_we), 0);
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    check("tag0_retire_we", int'(branch_we), 1);
    check("tag0_retire_idx", int'(write_idx), 0);
    step(0, 0, 0, 0, 0, 0, 0);
    check("tag1_blocks_tag3", int'(branch_we), 0);
    step(1, 8, 3, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 1, 0);
    step(1, 21, 0, 0, 0, 0, 0);
    check("full_retire_ready", int'(enq_ready), 1);
    check("full_retire_tag", int'(enq_tag), 1);
    check("full_retire_idx", int'(write_idx), 1);
    step(0, 0, 0, 0, 0, 0, 1);

    // Two branches on one index: second update sees forwarded state if enabled.
    step(1, 9, 1, 0, 0, 0, 0);
    step(1, 9, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
`ifdef BUQ_STATE_FWD_EN
    check("fwd_prev_state", int'(bp_prev_state), 2);
`else
    check("fwd_prev_state", int'(bp_prev_state), 1);
`endif

    // Flush with four valid entries and competing enqueue/resolve.
    for (int i = 0; i < 4; i++) step(1, 10 + i, 2, 0, 0, 0, 0);
    step(1, 3, 2, 1, 0, 1, 1);
    check("flush_tag", int'(enq_tag), 0);
    check("flush_ready", int'(enq_ready), 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, i, 1, 0);
    check("flush_no_we", int'(branch_we), 0);

    // Asynchronous reset while an update is being presented.
    step(1, 11, 3, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 1, 0);
    step(1, 12, 0, 0, 0, 0, 0);
    check("pre_rst_we", int'(branch_we), 1);
    rst = 1'b0;
    #1;
    model_reset();
    check("async_rst_we", int'(branch_we), 0);
    check("async_rst_tag", int'(enq_tag), 0);
    check("async_rst_prev", int'(bp_prev_state), 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Random traffic; small index range to exercise same-index forwarding.
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 9) < 6, $urandom_range(0, 15), $urandom_range(0, 3),
           $urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom_range(0, 1) == 1,
           $urandom_range(0, 99) < 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
